// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone bus arbiter.
// Holds the FSM state type, the default master count and one-hot decode.
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} arb_state_t;

  localparam int NUMM_DFLT = 3;
  localparam int IDXW = $clog2(NUMM_DFLT);

  function automatic int unsigned onehot2idx(input logic [31:0] oh);
    onehot2idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) onehot2idx = i;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational rotating priority encoder: first set req bit after last.
// Ports: req (requests), last (previous owner), pick (one-hot), pick_idx.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUMM = NUMM_DFLT,
  parameter int IW   = $clog2(NUMM)
) (
  input  logic [NUMM-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NUMM-1:0] pick,
  output logic [IW-1:0]   pick_idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = '0;
    for (int k = 1; k <= NUMM; k++) begin
      j = IW'((int'(last) + k) % NUMM);
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone bus-ownership arbiter with CYC locking.
// Ports: clk, rst (sync, high), cyc_i/stb_i per master, ack_i, err_i,
//   gnt_o (one-hot, registered), gnt_idx_o, busy_o, to_err_o, timeout_o.
// Define WB_ARB_TIMEOUT_EN to build the stalled-cycle watchdog.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int NUMM           = NUMM_DFLT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUMM-1:0]         cyc_i,
  input  logic [NUMM-1:0]         stb_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  output logic [NUMM-1:0]         gnt_o,
  output logic [$clog2(NUMM)-1:0] gnt_idx_o,
  output logic                    busy_o,
  output logic                    to_err_o,
  output logic                    timeout_o
);

  localparam int IW = $clog2(NUMM);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NUMM-1:0] gnt_q, gnt_d;
  logic [NUMM-1:0] pick;
  logic [IW-1:0]   pick_idx;

  wb_rr_picker #(.NUMM(NUMM)) u_pick (
    .req      (cyc_i),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          stall;
  logic          expire;

  // Owner strobing with no response this cycle.
  assign stall  = (state_q == OWNED) && stb_i[last_q]
                  && !ack_i && !err_i;
  assign expire = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !stall || expire)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

  assign to_err_o  = (state_q == ABORT);
  assign timeout_o = (state_q == ABORT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{stb_i, ack_i, err_i, 32'(TIMEOUT_CYCLES)};

  assign to_err_o  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NUMM - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // last_q doubles as the owner index while the bus is held.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|cyc_i) begin
          state_d = OWNED;
          gnt_d   = pick;
          last_d  = pick_idx;
        end
      end
      OWNED: begin
        if (!cyc_i[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d = ABORT;
        end
`endif
      end
      ABORT: begin
        if (!cyc_i[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          state_d = OWNED;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = |gnt_q;
  assign gnt_idx_o = IW'(onehot2idx(32'(gnt_q)));

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: directed steps then random traffic.
// Expected values come from a cycle-level ownership model kept here.
module tb_wb_arbiter_rr;

  localparam int N = 3;
  localparam int T = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cyc = '0;
  logic [N-1:0] stb = '0;
  logic         ack = 1'b0;
  logic         err = 1'b0;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         busy_o;
  logic         to_err_o;
  logic         timeout_o;

  always #5 clk = ~clk;

  wb_arbiter_rr #(.NUMM(N), .TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .cyc_i     (cyc),
    .stb_i     (stb),
    .ack_i     (ack),
    .err_i     (err),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .busy_o    (busy_o),
    .to_err_o  (to_err_o),
    .timeout_o (timeout_o)
  );

  int errors = 0;
  int checks = 0;

  int m_owner = -1;
  int m_last  = N - 1;
  int m_stall = 0;
  bit m_pulse = 1'b0;

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    return ((32'(v) >> i) & 32'd1) != 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_stall = 0;
      m_pulse = 1'b0;
    end else if (m_owner < 0) begin
      m_pulse = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int j = (m_last + k) % N;
        if (m_owner < 0 && bitof(cyc, j)) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_last  = m_owner;
        m_stall = 0;
      end
    end else if (!bitof(cyc, m_owner)) begin
      m_owner = -1;
      m_pulse = 1'b0;
    end else if (m_pulse) begin
      m_pulse = 1'b0;
      m_stall = 0;
    end else if (TO_EN) begin
      if (ack || err || !bitof(stb, m_owner)) m_stall = 0;
      else if (m_stall == T - 1) begin
        m_pulse = 1'b1;
        m_stall = 0;
      end else m_stall++;
    end
  endtask

  task automatic step();
    logic [31:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? 32'd0 : 32'(1 << m_owner);
    chk("gnt", 32'(gnt_o), eg);
    chk("busy", 32'(busy_o), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("idx", 32'(gnt_idx_o), 32'(m_owner));
    chk("to_err", 32'(to_err_o), 32'(m_pulse));
    chk("timeout", 32'(timeout_o), 32'(m_pulse));
  endtask

  task automatic drop_owner();
    if (m_owner >= 0) cyc = cyc & ~N'(1 << m_owner);
  endtask

  int exp1[4] = '{1, 2, 4, 1};

  initial begin
    // Reset with every master requesting
    rst = 1'b1;
    cyc = 3'b111;
    stb = 3'b111;
    step();
    step();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_idx", 32'(gnt_idx_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    step();
    chk("t1_first", 32'(gnt_o), 32'(exp1[0]));

    // Back-to-back rotation with an idle gap between owners
    for (int g = 1; g < 4; g++) begin
      ack = 1'b1;
      step();
      step();
      ack = 1'b0;
      drop_owner();
      step();
      chk("t1_gap", 32'(gnt_o), 32'd0);
      cyc = 3'b111;
      step();
      chk("t1_grant", 32'(gnt_o), 32'(exp1[g]));
    end

    // No preemption while master 1 holds the bus
    drop_owner();
    step();
    cyc = 3'b111;
    step();
    chk("t2_grant", 32'(gnt_o), 32'b010);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t2_hold", 32'(gnt_o), 32'b010);
    end
    cyc = 3'b101;
    step();
    chk("t2_gap", 32'(gnt_o), 32'd0);
    step();
    chk("t2_next", 32'(gnt_o), 32'b100);

    // Single requester
    cyc = 3'b000;
    step();
    cyc = 3'b010;
    step();
    chk("t3_gnt", 32'(gnt_o), 32'b010);
    chk("t3_idx", 32'(gnt_idx_o), 32'd1);
    chk("t3_busy", 32'(busy_o), 32'd1);
    cyc = 3'b000;
    step();
    chk("t3_rel", 32'(gnt_o), 32'd0);

    // Reset during ownership by master 2
    cyc = 3'b100;
    step();
    chk("t4_own2", 32'(gnt_o), 32'b100);
    cyc = 3'b101;
    rst = 1'b1;
    step();
    chk("t4_rst_gnt", 32'(gnt_o), 32'd0);
    chk("t4_rst_busy", 32'(busy_o), 32'd0);
    chk("t4_rst_err", 32'(to_err_o), 32'd0);
    rst = 1'b0;
    step();
    chk("t4_next", 32'(gnt_o), 32'b001);

    // Stalled owner
    cyc = 3'b000;
    step();
    cyc = 3'b001;
    stb = 3'b001;
    step();
    chk("stall_gnt", 32'(gnt_o), 32'b001);
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      step();
      chk("t5_quiet", 32'(to_err_o), 32'd0);
    end
    step();
    chk("t5_to_err", 32'(to_err_o), 32'd1);
    chk("t5_timeout", 32'(timeout_o), 32'd1);
    chk("t5_hold", 32'(gnt_o), 32'b001);
    step();
    chk("t5_one", 32'(to_err_o), 32'd0);
    chk("t5_hold2", 32'(gnt_o), 32'b001);
    cyc = 3'b000;
    step();
    cyc = 3'b001;
    step();
    for (int c = 0; c < 7; c++) step();
    ack = 1'b1;
    step();
    chk("t5_ack_wins", 32'(to_err_o), 32'd0);
    ack = 1'b0;
    step();
    chk("t5_ack_none", 32'(timeout_o), 32'd0);
`else
    for (int c = 0; c < 1000; c++) begin
      step();
      chk("t6_to_err", 32'(to_err_o), 32'd0);
      chk("t6_gnt", 32'(gnt_o), 32'b001);
    end
`endif

    // Random traffic against the model
    cyc = '0;
    stb = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bitof(cyc, i)) begin
          if ($urandom_range(2) == 0) cyc = cyc | N'(1 << i);
        end else if (i == m_owner) begin
          if ($urandom_range(3) == 0) cyc = cyc & ~N'(1 << i);
        end
      end
      stb = '0;
      for (int i = 0; i < N; i++)
        if (bitof(cyc, i) && $urandom_range(3) != 0)
          stb = stb | N'(1 << i);
      ack = ($urandom_range(2) == 0);
      err = ($urandom_range(9) == 0);
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;
    ack = 1'b0;
    err = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
